adc_avg_scheduler: RTL and testbench
====================================

ADC_AVG_SCHEDULER -- requirements
Module: adc_avg_scheduler

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, the clk frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 4096, the maximum cycles allowed from convert to flag.
REQ-003 SHALL have port clk  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start_en  input  1  level; high enables periodic sampling.
REQ-006 SHALL have port period_sel  input  2  burst period = (CLK_HZ/4) << period_sel cycles, i.e. 0.25/0.5/1/2 s.
REQ-007 SHALL have port avg_sel  input  2  samples per burst N = 1 << avg_sel, i.e. 1/2/4/8.
REQ-008 SHALL have port flag  input  1  ADC conversion-done indication; may be held for several cycles.
REQ-009 SHALL have port ad  input  12  ADC result; valid in the cycle flag rises.
REQ-010 SHALL have port convert  output  1  single-cycle conversion-start pulse to the ADC.
REQ-011 SHALL have port num  output  12  averaged result for the display.
REQ-012 SHALL have port valid  output  1  single-cycle pulse in the cycle num updates.
REQ-013 SHALL have port busy  output  1  high while a burst is in progress.
REQ-014 SHALL have port timeout_err  output  1  sticky; set when a conversion times out.

Function
REQ-015 SHALL implement states IDLE, WAIT_TICK, START, WAIT_FLAG, ACCUM and DONE.
REQ-016 SHALL transition IDLE->WAIT_TICK on start_en=1; in any state, start_en=0 SHALL force IDLE on the next edge, discard the accumulator and hold num.
REQ-017 SHALL run the tick counter only while start_en=1, clear it to 0 otherwise, and raise a 1-cycle tick at count period-1 before wrapping to 0.
REQ-018 SHALL, on tick in WAIT_TICK, latch period_sel/avg_sel for the burst, clear the accumulator and sample count, and enter START.
REQ-019 SHALL treat a tick arriving outside WAIT_TICK as dropped: no queuing and no error.
REQ-020 SHALL drive convert=1 for exactly the one cycle spent in START, then enter WAIT_FLAG.
REQ-021 SHALL, in WAIT_FLAG, accept only a rising edge of flag (registered previous value); flag levels or edges seen in other states SHALL be ignored.
REQ-022 SHALL, on an accepted flag edge, add ad to a 15-bit accumulator in ACCUM and increment the count; if count<N, go to START (next convert 2 cycles after the flag edge), else go to DONE.
REQ-023 SHALL, in DONE, set num = accumulator >> latched avg_sel (truncating), pulse valid for 1 cycle, then return to WAIT_TICK.
REQ-024 SHALL count WAIT_FLAG cycles; reaching TIMEOUT_CYC SHALL set timeout_err, abandon the burst (num unchanged, no valid) and return to WAIT_TICK.
REQ-025 SHALL clear timeout_err only on rst or on a rising edge of start_en.
REQ-026 SHALL assert busy in the START, WAIT_FLAG, ACCUM and DONE states.
REQ-027 SHALL NOT let changes to period_sel/avg_sel mid-burst affect the current burst; a new period_sel takes effect at the next tick-counter wrap.

Reset
REQ-028 SHALL, on rst, asynchronously set: state IDLE, convert 0, num 0, valid 0, busy 0, timeout_err 0, counters 0, accumulator 0, flag history 0.
REQ-029 SHALL issue no convert pulse in the first cycle after rst deasserts.

Structure
REQ-030 SHALL define the state enumeration and the constants AD_W=12 and ACC_W=15 in shared package adc_ctrl_pkg.
REQ-031 SHALL place the period divider in one sub-module, sample_tick_gen (inputs clk, rst, en, period_sel; output tick).

Verification (CLK_HZ=400 so the base period is 100 cycles; TIMEOUT_CYC=64)
REQ-032 SHALL verify: start_en=1, period_sel=0, avg_sel=0, flag returned 10 cycles after each convert with ad=0x123 -> one convert per 100 cycles, num=0x123 with valid pulse, busy low between bursts.
REQ-033 SHALL verify: avg_sel=3, ad sequence 0,1,...,7 -> 8 converts, each 2 cycles after the preceding flag edge, then num=3 (28>>3).
REQ-034 SHALL verify: avg_sel=2, all ad=0xFFF -> no overflow, num=0xFFF.
REQ-035 SHALL verify: flag never returned -> timeout_err=1 at convert+64, num unchanged, no valid pulse, next tick still issues convert; start_en toggled 0->1 -> timeout_err=0.
REQ-036 SHALL verify: start_en dropped during WAIT_FLAG, then a late flag -> state IDLE, no accumulation, no valid pulse.
REQ-037 SHALL verify: rst asserted mid-burst and asynchronously between edges -> all outputs 0 immediately, no convert in the first cycle after release.

Source files
------------

// File: rtl/adc_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the ADC averaging scheduler.
package adc_ctrl_pkg;

  localparam int AD_W  = 12;
  localparam int ACC_W = 15;
  localparam int SCNT_W = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WAIT_TICK = 3'd1;
  localparam state_t ST_START     = 3'd2;
  localparam state_t ST_WAIT_FLAG = 3'd3;
  localparam state_t ST_ACCUM     = 3'd4;
  localparam state_t ST_DONE      = 3'd5;

  function automatic logic [SCNT_W-1:0] samples_per_burst(input logic [1:0] avg_sel);
    return 4'd1 << avg_sel;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Burst-period divider: one-cycle tick every (CLK_HZ/4) << period_sel cycles while en is high.
module sample_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] period_sel,
  output logic       tick
);

  localparam int BASE  = CLK_HZ / 4;
  localparam int CNT_W = $clog2(BASE * 8);

  logic [CNT_W-1:0] cnt_q, cnt_d, last_cnt;
  logic [1:0]       sel_q, sel_d;

  // The period in use is only re-sampled at a wrap, so a new period_sel never cuts a period short.
  always_comb begin
    last_cnt = CNT_W'((BASE << sel_q) - 1);
    tick     = en && (cnt_q == last_cnt);
  end

  // NOTE: every variable assigned here gets a default first, so no latch can be inferred.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    sel_d = sel_q;
    if (!en || tick) begin
      cnt_d = '0;
      sel_d = period_sel;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

endmodule

// File: rtl/adc_avg_scheduler.sv
// Periodic ADC burst scheduler: issues 1/2/4/8 conversions per tick and publishes their average.
module adc_avg_scheduler
  import adc_ctrl_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_en,
  input  logic [1:0]      period_sel,
  input  logic [1:0]      avg_sel,
  input  logic            flag,
  input  logic [AD_W-1:0] ad,
  output logic            convert,
  output logic [AD_W-1:0] num,
  output logic            valid,
  output logic            busy,
  output logic            timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t              state_q, state_d;
  logic                flag_q, flag_d, start_en_q, start_en_d;
  logic [1:0]          avg_q, avg_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;
  logic [TW-1:0]       wait_q, wait_d;
  logic [AD_W-1:0]     ad_q, ad_d, num_q, num_d;
  logic                valid_q, valid_d, err_q, err_d;
  logic                tick, flag_rise;

  sample_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk        (clk),
    .rst        (rst),
    .en         (start_en),
    .period_sel (period_sel),
    .tick       (tick)
  );

  assign flag_rise = flag && !flag_q;

  always_comb begin
    state_d    = state_q;
    flag_d     = flag;
    start_en_d = start_en;
    avg_d      = avg_q;
    acc_d      = acc_q;
    scnt_d     = scnt_q;
    wait_d     = wait_q;
    ad_d       = ad_q;
    num_d      = num_q;
    valid_d    = 1'b0;
    err_d      = err_q;

    if (start_en && !start_en_q) err_d = 1'b0;

    if (!start_en) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      scnt_d  = '0;
      wait_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE:      state_d = ST_WAIT_TICK;
        ST_WAIT_TICK: if (tick) begin
          avg_d   = avg_sel;
          acc_d   = '0;
          scnt_d  = '0;
          state_d = ST_START;
        end
        ST_START: begin
          wait_d  = TW'(1);
          state_d = ST_WAIT_FLAG;
        end
        // wait_q counts cycles since convert; reaching TIMEOUT_CYC abandons the burst.
        ST_WAIT_FLAG: if (flag_rise) begin
          ad_d    = ad;
          state_d = ST_ACCUM;
        end else if (wait_q >= TW'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = ST_WAIT_TICK;
        end else begin
          wait_d = wait_q + 1'b1;
        end
        ST_ACCUM: begin
          acc_d   = acc_q + ACC_W'(ad_q);
          scnt_d  = scnt_q + 1'b1;
          state_d = ((scnt_q + 1'b1) < samples_per_burst(avg_q)) ? ST_START : ST_DONE;
        end
        ST_DONE: begin
          num_d   = AD_W'(acc_q >> avg_q);
          valid_d = 1'b1;
          state_d = ST_WAIT_TICK;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      flag_q     <= 1'b0;
      start_en_q <= 1'b0;
      avg_q      <= '0;
      acc_q      <= '0;
      scnt_q     <= '0;
      wait_q     <= '0;
      ad_q       <= '0;
      num_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      flag_q     <= flag_d;
      start_en_q <= start_en_d;
      avg_q      <= avg_d;
      acc_q      <= acc_d;
      scnt_q     <= scnt_d;
      wait_q     <= wait_d;
      ad_q       <= ad_d;
      num_q      <= num_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign convert     = (state_q == ST_START);
  assign busy        = state_q inside {ST_START, ST_WAIT_FLAG, ST_ACCUM, ST_DONE};
  assign num         = num_q;
  assign valid       = valid_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_adc_avg_scheduler.sv
// Directed-plus-random bench for adc_avg_scheduler with a small averaging reference model.
module tb_adc_avg_scheduler;

  localparam int CLK_HZ      = 400;
  localparam int TIMEOUT_CYC = 64;
  localparam int PERIOD      = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_en = 1'b0;
  logic [1:0]  period_sel = 2'd0;
  logic [1:0]  avg_sel = 2'd0;
  logic        flag = 1'b0;
  logic [11:0] ad = 12'd0;
  logic        convert, valid, busy, timeout_err;
  logic [11:0] num;

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          exp_c = 0;
  logic [11:0] last_num = 12'd0;
  logic [11:0] vals[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_avg_scheduler #(.CLK_HZ(CLK_HZ), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_en    (start_en),
    .period_sel  (period_sel),
    .avg_sel     (avg_sel),
    .flag        (flag),
    .ad          (ad),
    .convert     (convert),
    .num         (num),
    .valid       (valid),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_conv(input string tag, output int c);
    int k;
    k = 0;
    while (convert !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check({tag, " convert seen"}, convert, 1);
    c = cyc;
  endtask

  task automatic watch_quiet(input string tag, input int ncyc);
    logic saw_v, saw_c;
    saw_v = 1'b0;
    saw_c = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      saw_v |= valid;
      saw_c |= convert;
    end
    check({tag, " no valid"}, saw_v, 0);
    check({tag, " no convert"}, saw_c, 0);
    check({tag, " num held"}, num, last_num);
  endtask

  // One full burst: answers each convert after d cycles with vals[i], holds flag 2 cycles.
  task automatic run_burst(input string tag, input int avg, input int dmin, input int dmax);
    int c, d, n, sum;
    logic [11:0] exp_num;
    n   = 1 << avg;
    sum = 0;
    avg_sel = 2'(avg);
    wait_conv(tag, c);
    check({tag, " first convert cycle"}, c, exp_c);
    exp_c = c + PERIOD;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, " convert one cycle"}, convert, 0);
      check({tag, " busy in burst"}, busy, 1);
      if (i == 0) avg_sel = 2'($urandom);
      d = $urandom_range(dmax, dmin);
      repeat (d - 1) @(negedge clk);
      flag = 1'b1;
      ad   = vals[i];
      sum += int'(vals[i]);
      @(negedge clk);
      ad = 12'($urandom);
      @(negedge clk);
      flag = 1'b0;
      if (i < n - 1) check({tag, " convert 2 after flag"}, convert, 1);
      else begin
        check({tag, " no convert after last"}, convert, 0);
        check({tag, " valid not early"}, valid, 0);
      end
    end
    exp_num = 12'(sum / n);
    @(negedge clk);
    check({tag, " valid pulse"}, valid, 1);
    check({tag, " num"}, num, exp_num);
    check({tag, " busy low after"}, busy, 0);
    last_num = exp_num;
    @(negedge clk);
    check({tag, " valid single"}, valid, 0);
  endtask

  initial begin
    int c;
    logic saw_v;

    @(negedge clk);
    check("reset convert", convert, 0);
    check("reset num", num, 0);
    check("reset valid", valid, 0);
    check("reset busy", busy, 0);
    check("reset err", timeout_err, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset convert", convert, 0);

    @(negedge clk);
    start_en = 1'b1;
    exp_c = cyc + PERIOD;

    for (int i = 0; i < 8; i++) vals[i] = 12'h123;
    for (int k = 0; k < 3; k++) run_burst("single", 0, 10, 10);

    for (int i = 0; i < 8; i++) vals[i] = 12'(i);
    run_burst("avg8 ramp", 3, 1, 8);

    for (int i = 0; i < 8; i++) vals[i] = 12'hFFF;
    run_burst("avg4 full", 2, 1, 8);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) vals[i] = 12'($urandom);
      run_burst("random", int'($urandom_range(3, 0)), 1, 6);
    end

    for (int i = 0; i < 8; i++) vals[i] = 12'($urandom);
    run_burst("period a", 0, 2, 4);
    period_sel = 2'd1;
    run_burst("period b", 1, 2, 4);
    period_sel = 2'd0;
    exp_c += PERIOD;
    run_burst("period c", 0, 2, 4);

    run_burst("tick drop", 3, 12, 12);
    exp_c += PERIOD;

    wait_conv("timeout", c);
    check("timeout convert cycle", c, exp_c);
    saw_v = 1'b0;
    repeat (63) begin
      @(negedge clk);
      saw_v |= valid;
    end
    check("timeout err not early", timeout_err, 0);
    @(negedge clk);
    check("timeout err set", timeout_err, 1);
    check("timeout busy low", busy, 0);
    check("timeout no valid", saw_v, 0);
    watch_quiet("timeout", 35);
    exp_c = c + PERIOD;
    run_burst("timeout recover", 1, 2, 5);
    check("timeout err sticky", timeout_err, 1);
    start_en = 1'b0;
    @(negedge clk);
    start_en = 1'b1;
    exp_c = cyc + PERIOD;
    check("err held while disabled", timeout_err, 1);
    @(negedge clk);
    check("err cleared by start_en", timeout_err, 0);

    wait_conv("disable", c);
    check("disable convert cycle", c, exp_c);
    repeat (3) @(negedge clk);
    start_en = 1'b0;
    @(negedge clk);
    check("disable busy low", busy, 0);
    @(negedge clk);
    flag = 1'b1;
    ad   = 12'h555;
    repeat (2) @(negedge clk);
    flag = 1'b0;
    watch_quiet("late flag", 30);
    check("disable err clear", timeout_err, 0);
    start_en = 1'b1;
    exp_c = cyc + PERIOD;
    vals[0] = 12'h0AB;
    run_burst("after disable", 0, 2, 5);

    avg_sel = 2'd1;
    wait_conv("reset burst", c);
    check("reset burst convert cycle", c, exp_c);
    #2 rst = 1'b1;
    #1;
    check("async rst convert", convert, 0);
    check("async rst num", num, 0);
    check("async rst valid", valid, 0);
    check("async rst busy", busy, 0);
    check("async rst err", timeout_err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("release convert", convert, 0);
    check("release busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
